dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//   Parametrised data memory with load/store unit for the RISC-V core. Replaces the flat word
//   array with a byte-addressed, little-endian memory that supports:
//   - LB/LH/LW/LBU/LHU and SB/SH/SW (byte-lane stores, sign/zero-extended loads);
//   - a valid/ready request port with configurable response latency;
//   - misalignment, range and illegal-funct3 faults;
//   - a sequential clear-on-reset FSM, so no single-cycle full-array reset is needed.
// PARAMETERS
//   DEPTH_WORDS     256  number of 32-bit words; power of 2, >= 4
//   LATENCY         1    wait cycles between accept and response, 0..15
//   CLEAR_ON_RESET  1    1: zero every word after reset; 0: skip clear, contents undefined
// PORTS
//   clk         in   1   clock, rising edge
//   rst         in   1   synchronous, active-high reset
//   req_valid   in   1   request present
//   req_ready   out  1   block can accept a request this cycle
//   req_we      in   1   1 = store, 0 = load
//   req_funct3  in   3   RISC-V funct3 (width and signedness)
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data; low byte/half used for SB/SH
//   rsp_valid   out  1   one-cycle response strobe
//   rsp_rdata   out  32  extended load data; 0 for stores and faults
//   rsp_fault   out  1   request rejected (no memory side effect)
//   busy        out  1   clearing or transaction outstanding
// BEHAVIOUR
//   States: CLEAR, IDLE, WAIT, RESP.
//   - Only IDLE drives req_ready=1. Handshake is req_valid & req_ready at a rising edge.
//   Reset: while rst=1 and on the first edge after it, the FSM enters CLEAR with clr_ptr=0
//     (IDLE if CLEAR_ON_RESET=0). rsp_valid=0, rsp_rdata=0, rsp_fault=0, req_ready=0, busy=1.
//   CLEAR: writes 0 to word clr_ptr each cycle, then increments clr_ptr.
//     - After word DEPTH_WORDS-1 the next state is IDLE: exactly DEPTH_WORDS cycles.
//     - req_ready=0 and busy=1 throughout.
//   Accept edge (IDLE):
//     - Word index = req_addr[31:2]; byte lane = req_addr[1:0].
//     - Faults:
//       - misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0;
//       - out of range: word index >= DEPTH_WORDS;
//       - illegal funct3: load funct3 in {011,110,111}; store funct3 > 010.
//     - Fault: no write; rdata register := 0; fault register := 1.
//     - Store without fault: write enabled byte lanes only at this edge.
//       - SB: 1 lane; SH: lanes {1:0} or {3:2}; SW: all lanes. Other lanes unchanged.
//     - Load without fault: read the word at this edge.
//       - Select the byte/half by lane; sign-extend for LB/LH, zero-extend for LBU/LHU.
//       - Register the result; rdata register := 0 for stores.
//     - Next state: WAIT with wait counter = LATENCY; RESP if LATENCY=0.
//   WAIT: counter decrements each cycle; at 1 -> RESP. busy=1, req_ready=0.
//   RESP: exactly one cycle.
//     - rsp_valid=1; rsp_rdata and rsp_fault from registers; next state IDLE.
//     - Outside RESP: rsp_valid=0, rsp_fault=0, rsp_rdata=0.
//   Timing: response appears LATENCY+1 cycles after the accept edge.
//     - Back-to-back requests: one every LATENCY+2 cycles.
//     - A load immediately after a store to the same word sees the stored data.
//   Reset mid-operation (any state): the pending response is dropped and never strobed;
//     CLEAR restarts at word 0.
//   req_* inputs are ignored whenever req_ready=0.
// TESTING
//   T1 Reset, CLEAR_ON_RESET=1, DEPTH_WORDS=256 -> req_ready=0 for 256 cycles, then 1;
//      LW 0x3FC returns 0x00000000.
//   T2 SW 0x10 = 0x8899AABB; SB 0x11 = 0x5C; LW 0x10 -> 0x88995CBB.
//      LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088.
//   T3 SH 0x22 = 0xF00D; LH 0x22 -> 0xFFFFF00D; LHU 0x22 -> 0x0000F00D;
//      LW 0x20 -> 0xF00Dxxxx with the low half unchanged.
//   T4 LW 0x05, SH 0x07, LB 0x400 (DEPTH 256), funct3=011 -> rsp_fault=1, rsp_rdata=0;
//      a following LW of the targeted words shows no change.
//   T5 LATENCY=3: accept at cycle N -> rsp_valid only in cycle N+4;
//      req_ready low in N+1..N+4, high again in N+5.
//   T6 rst asserted in WAIT after an SW -> no rsp_valid; CLEAR restarts at word 0;
//      the stored word reads 0 afterwards.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed, little-endian data memory with a RISC-V load/store unit.
// Single outstanding request, programmable response latency and a sequential clear after reset.
module dmem_lsu #(
  parameter int DEPTH_WORDS    = 256,
  parameter int LATENCY        = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int            AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]    LAT       = 4'(LATENCY);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [3:0]    wait_cnt;
  logic [31:0]   rdata_p1;
  logic          fault_p1;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          misaligned;
  logic          illegal;
  logic          fault;
  logic          accept;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;

  // Select the addressed byte/half and extend it according to funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  sel);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = sel[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign word_idx     = req_addr[AW+1:2];
  assign lane         = req_addr[1:0];
  assign out_of_range = |req_addr[31:AW+2];
  assign misaligned   = ((req_funct3[1:0] == 2'b01) && lane[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (lane != 2'b00));
  assign illegal      = req_we ? (req_funct3 > 3'b010)
                               : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
  assign fault        = misaligned | out_of_range | illegal;

  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = rst || (state != S_IDLE);
  assign rsp_valid = (state == S_RESP) && !rst;
  assign rsp_rdata = rsp_valid ? rdata_p1 : 32'd0;
  assign rsp_fault = rsp_valid && fault_p1;

  // Narrow stores replicate their data across the word so the lane mask alone picks the bytes.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if ((state == S_CLEAR) && !rst) begin
      mem[clr_ptr] <= 32'd0;
    end else if (accept && req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // Stage p1: response payload captured at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      fault_p1 <= fault;
      rdata_p1 <= (fault || req_we) ? 32'd0 : load_extend(mem[word_idx], req_funct3, lane);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_ptr  <= '0;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_WORD) state <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            wait_cnt <= LAT;
            state    <= (LAT == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: fixed load/store cases, faults, latency/throughput,
// reset behaviour and a randomised run against a byte-array reference memory.
module tb_dmem_lsu;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  string       tag_q[$];
  logic [7:0]  mb [0:4*DEPTH-1];

  dmem_lsu #(
    .DEPTH_WORDS   (DEPTH),
    .LATENCY       (LAT),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // Issue one request; the expected response is queued now, the observed one when it strobes.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_fault);
    int n;
    exp_q.push_back({exp_fault, exp_rdata});
    tag_q.push_back(tag);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid) begin
      obs_q.push_back({rsp_fault, rsp_rdata});
    end else begin
      $display("FAIL %s: no response within 40 cycles", tag);
      obs_q.push_back(~{exp_fault, exp_rdata});
    end
  endtask

  task automatic test_reset(input string tag);
    int n;
    logic [32:0] e, o;
    string t;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'd0 || rsp_fault !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_in_reset: ready=%0b busy=%0b vld=%0b rdata=%08h fault=%0b, expected 0 1 0 00000000 0",
               tag, req_ready, busy, rsp_valid, rsp_rdata, rsp_fault);
    end
    rst = 1'b0;
    #1;
    n = 0;
    while (!req_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== DEPTH || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_clear_cycles: got %0d cycles busy=%0b, expected %0d cycles busy=0",
               tag, n, busy, DEPTH);
    end
    do_req({tag, "_lw_3fc"}, 1'b0, 3'b010, 32'h3FC, 32'd0, 32'h0000_0000, 1'b0);
    do_req({tag, "_lw_010"}, 1'b0, 3'b010, 32'h010, 32'd0, 32'h0000_0000, 1'b0);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got fault=%0b rdata=%08h, expected fault=%0b rdata=%08h", t, o[32], o[31:0], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_store_load();
    logic [32:0] e, o;
    string t;
    do_req("t2_sw",      1'b1, 3'b010, 32'h10, 32'h8899AABB, 32'h0000_0000, 1'b0);
    do_req("t2_sb",      1'b1, 3'b000, 32'h11, 32'h1234565C, 32'h0000_0000, 1'b0);
    do_req("t2_lw",      1'b0, 3'b010, 32'h10, 32'd0,        32'h88995CBB,  1'b0);
    do_req("t2_lb_13",   1'b0, 3'b000, 32'h13, 32'd0,        32'hFFFFFF88,  1'b0);
    do_req("t2_lbu_13",  1'b0, 3'b100, 32'h13, 32'd0,        32'h00000088,  1'b0);
    do_req("t2_lb_11",   1'b0, 3'b000, 32'h11, 32'd0,        32'h0000005C,  1'b0);
    do_req("t2_lh_12",   1'b0, 3'b001, 32'h12, 32'd0,        32'hFFFF8899,  1'b0);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got fault=%0b rdata=%08h, expected fault=%0b rdata=%08h", t, o[32], o[31:0], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_halfword();
    logic [32:0] e, o;
    string t;
    do_req("t3_sw",      1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0000_0000, 1'b0);
    do_req("t3_sh",      1'b1, 3'b001, 32'h22, 32'hABCDF00D, 32'h0000_0000, 1'b0);
    do_req("t3_lh_22",   1'b0, 3'b001, 32'h22, 32'd0,        32'hFFFFF00D,  1'b0);
    do_req("t3_lhu_22",  1'b0, 3'b101, 32'h22, 32'd0,        32'h0000F00D,  1'b0);
    do_req("t3_lw_20",   1'b0, 3'b010, 32'h20, 32'd0,        32'hF00D5678,  1'b0);
    do_req("t3_lh_20",   1'b0, 3'b001, 32'h20, 32'd0,        32'h00005678,  1'b0);
    do_req("t3_lb_23",   1'b0, 3'b000, 32'h23, 32'd0,        32'hFFFFFFF0,  1'b0);
    do_req("t3_lbu_21",  1'b0, 3'b100, 32'h21, 32'd0,        32'h00000056,  1'b0);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got fault=%0b rdata=%08h, expected fault=%0b rdata=%08h", t, o[32], o[31:0], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_faults();
    logic [32:0] e, o;
    string t;
    do_req("t4_lw_05",    1'b0, 3'b010, 32'h005, 32'd0,        32'd0, 1'b1);
    do_req("t4_sh_07",    1'b1, 3'b001, 32'h007, 32'h1234FFFF, 32'd0, 1'b1);
    do_req("t4_lb_400",   1'b0, 3'b000, 32'h400, 32'd0,        32'd0, 1'b1);
    do_req("t4_ld_f011",  1'b0, 3'b011, 32'h020, 32'd0,        32'd0, 1'b1);
    do_req("t4_ld_f110",  1'b0, 3'b110, 32'h020, 32'd0,        32'd0, 1'b1);
    do_req("t4_lh_21",    1'b0, 3'b001, 32'h021, 32'd0,        32'd0, 1'b1);
    do_req("t4_lhu_23",   1'b0, 3'b101, 32'h023, 32'd0,        32'd0, 1'b1);
    do_req("t4_lw_22",    1'b0, 3'b010, 32'h022, 32'd0,        32'd0, 1'b1);
    do_req("t4_sw_22",    1'b1, 3'b010, 32'h022, 32'hFFFFFFFF, 32'd0, 1'b1);
    do_req("t4_sw_400",   1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, 32'd0, 1'b1);
    do_req("t4_sb_hi",    1'b1, 3'b000, 32'h8000_0004, 32'hFF, 32'd0, 1'b1);
    do_req("t4_st_f100",  1'b1, 3'b100, 32'h004, 32'hFFFFFFFF, 32'd0, 1'b1);
    do_req("t4_st_f011",  1'b1, 3'b011, 32'h024, 32'hFFFFFFFF, 32'd0, 1'b1);
    do_req("t4_chk_04",   1'b0, 3'b010, 32'h004, 32'd0, 32'h0000_0000, 1'b0);
    do_req("t4_chk_00",   1'b0, 3'b010, 32'h000, 32'd0, 32'h0000_0000, 1'b0);
    do_req("t4_chk_20",   1'b0, 3'b010, 32'h020, 32'd0, 32'hF00D5678,  1'b0);
    do_req("t4_chk_24",   1'b0, 3'b010, 32'h024, 32'd0, 32'h0000_0000, 1'b0);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got fault=%0b rdata=%08h, expected fault=%0b rdata=%08h", t, o[32], o[31:0], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_latency();
    int n;
    logic [32:0] e, o;
    string t;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'd0;
    @(posedge clk);
    #1;
    // Request stays asserted as a store while the block is busy; it must be ignored.
    req_we = 1'b1; req_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== (k == LAT + 1) || req_ready !== (k >= LAT + 2) || busy !== (k <= LAT + 1)) begin
        n_bad++;
        $display("FAIL t5_timing cycle N+%0d: vld=%0b ready=%0b busy=%0b, expected %0b %0b %0b",
                 k, rsp_valid, req_ready, busy, k == LAT + 1, k >= LAT + 2, k <= LAT + 1);
      end
      if (k == LAT + 1) begin
        n_cmp++;
        if (rsp_rdata !== 32'h88995CBB || rsp_fault !== 1'b0) begin
          n_bad++;
          $display("FAIL t5_rdata: got fault=%0b rdata=%08h, expected fault=0 rdata=88995cbb", rsp_fault, rsp_rdata);
        end
        req_valid = 1'b0;
      end
    end
    do_req("t5_ignored_store", 1'b0, 3'b010, 32'h10, 32'd0, 32'h88995CBB, 1'b0);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got fault=%0b rdata=%08h, expected fault=%0b rdata=%08h", t, o[32], o[31:0], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nrsp;
    int acc[$];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'd0;
    cyc = 0;
    nrsp = 0;
    while (cyc < 200 && (acc.size() < 3 || nrsp < 3)) begin
      if (rsp_valid) begin
        nrsp++;
        n_cmp++;
        if (rsp_rdata !== 32'hF00D5678 || rsp_fault !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_rdata: got fault=%0b rdata=%08h, expected fault=0 rdata=f00d5678", rsp_fault, rsp_rdata);
        end
      end
      if (req_ready && req_valid) begin
        acc.push_back(cyc);
        if (acc.size() == 3) begin
          @(posedge clk);
          #1;
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (acc.size() != 3 || nrsp != 3) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d accepts %0d responses, expected 3 and 3", acc.size(), nrsp);
    end else begin
      n_cmp++;
      if (acc[1] - acc[0] != LAT + 2 || acc[2] - acc[1] != LAT + 2) begin
        n_bad++;
        $display("FAIL b2b_spacing: got %0d and %0d cycles, expected %0d", acc[1] - acc[0], acc[2] - acc[1], LAT + 2);
      end
    end
  endtask

  task automatic test_random();
    logic        we, oor, ill, mis, flt;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, er;
    logic [32:0] e, o;
    int          a;
    string       t;
    for (int i = 0; i < 4 * DEPTH; i++) mb[i] = 8'h00;
    for (int i = 0; i < 48; i++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      wdata = $urandom;
      case ($urandom_range(0, 7))
        0:       addr = 32'h400 + 32'($urandom_range(0, 15));
        1:       addr = {1'b1, 31'($urandom_range(0, 63))};
        default: addr = 32'($urandom_range(0, 63));
      endcase
      oor = (addr >= 32'd1024);
      ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      mis = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
      flt = oor || ill || mis;
      er  = 32'd0;
      if (!flt) begin
        a = int'(addr[9:0]);
        if (we) begin
          mb[a] = wdata[7:0];
          if (f3 != 3'd0) mb[a+1] = wdata[15:8];
          if (f3 == 3'd2) begin
            mb[a+2] = wdata[23:16];
            mb[a+3] = wdata[31:24];
          end
        end else begin
          case (f3)
            3'd0:    er = {{24{mb[a][7]}}, mb[a]};
            3'd1:    er = {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
            3'd2:    er = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
            3'd4:    er = {24'd0, mb[a]};
            3'd5:    er = {16'd0, mb[a+1], mb[a]};
            default: er = 32'd0;
          endcase
        end
      end
      do_req($sformatf("rand_%0d we=%0b f3=%0d addr=%08h", i, we, f3, addr), we, f3, addr, wdata, er, flt);
    end
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got fault=%0b rdata=%08h, expected fault=%0b rdata=%08h", t, o[32], o[31:0], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n, strobes;
    logic [32:0] e, o;
    string t;
    do_req("t6_seed_sw", 1'b1, 3'b010, 32'h34, 32'h01020304, 32'd0, 1'b0);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_wait_state: busy=%0b ready=%0b vld=%0b, expected 1 0 0", busy, req_ready, rsp_valid);
    end
    rst = 1'b1;
    strobes = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n = 0;
    while (!req_ready && n < 2000) begin
      if (rsp_valid) strobes++;
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (strobes != 0 || n != DEPTH) begin
      n_bad++;
      $display("FAIL t6_drop_and_clear: got %0d strobes %0d clear cycles, expected 0 and %0d", strobes, n, DEPTH);
    end
    do_req("t6_lw_30", 1'b0, 3'b010, 32'h30, 32'd0, 32'h0000_0000, 1'b0);
    do_req("t6_lw_34", 1'b0, 3'b010, 32'h34, 32'd0, 32'h0000_0000, 1'b0);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s: got fault=%0b rdata=%08h, expected fault=%0b rdata=%08h", t, o[32], o[31:0], e[32], e[31:0]);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    test_reset("t1");
    test_store_load();
    test_halfword();
    test_faults();
    test_latency();
    test_back_to_back();
    test_reset("t1b");
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
